barrel_shift_arbiter: RTL
=========================

// Module: barrel_shift_arbiter
// PURPOSE
//  Shares one 8-bit barrel shifter datapath between two requesters using valid/ready handshakes.
//  Arbitration is round-robin.
//  Each accepted op is shifted or rotated, then registered into a one-entry output slot.
//  The result is tagged with the source requester.
//  Sits between the two issuing units and the consumer of shifted results.
// PARAMETERS
//  WIDTH  8  data width; must be a power of 2
//  SHW    3  shift-amount width; equals log2(WIDTH)
//  CNTW   8  width of the per-requester grant counters
// PORTS
//  clk        in   1      single clock; all state updates on its rising edge
//  rst        in   1      synchronous reset, active-high
//  in0_valid  in   1      requester 0 has an op
//  in0_ready  out  1      requester 0 op accepted this cycle
//  in0_data   in   WIDTH  operand
//  in0_amt    in   SHW    shift amount, 0..WIDTH-1
//  in0_dir    in   1      0 = left, 1 = right
//  in0_rot    in   1      0 = logical shift (zero fill), 1 = rotate
//  in1_*      same set as in0_* for requester 1
//  out_valid  out  1      result slot holds a result
//  out_ready  in   1      consumer takes the result
//  out_data   out  WIDTH  shifted/rotated result
//  out_src    out  1      requester id of the result (0/1)
//  gcnt0      out  CNTW   count of ops accepted from requester 0 (wraps)
//  gcnt1      out  CNTW   count of ops accepted from requester 1 (wraps)
// BEHAVIOUR
//  - Reset (synchronous, active-high):
//    - out_valid=0, out_data=0, out_src=0, gcnt0=0, gcnt1=0.
//    - last_grant=1, so requester 0 wins the first tie.
//    - While rst is high, in0_ready=in1_ready=0.
//  - Slot FSM with states EMPTY and FULL:
//    - slot_free = EMPTY | (FULL & out_ready).
//    - EMPTY -> FULL on a grant.
//    - FULL -> EMPTY on out_ready with no grant.
//    - FULL -> FULL on out_ready with a grant (back-to-back refill, no bubble).
//    - FULL holds while out_ready=0; out_data/out_src stay stable.
//  - Grant (combinational, same cycle):
//    - Only when slot_free.
//    - One valid requester: grant it.
//    - Both valid: grant the one != last_grant.
//    - inK_ready = grantK; at most one ready per cycle.
//    - last_grant updates only on a grant.
//  - Latency: op accepted at edge N appears as out_valid=1 after edge N.
//    Sustains 1 op/cycle with out_ready=1.
//  - Datapath (evaluated on the granted op only):
//    - Shift, dir=0: data << amt.
//    - Shift, dir=1: data >> amt.
//    - Rotate: bits wrap around modulo WIDTH.
//    - amt=0 passes data through unchanged.
//  - Counters: gcntK increments on each accept from K and wraps 2^CNTW-1 -> 0 silently.
//  - Boundaries:
//    - A requester dropping valid without ready is legal and is not an accept.
//    - No op is duplicated or lost under backpressure.
//    - rst mid-operation discards the held result.
//    - Requesters must re-present the op after reset.
// STRUCTURE
//  - Shared package bshift_pkg holds:
//    - WIDTH and SHW defaults.
//    - DIR_LEFT/DIR_RIGHT and MODE_SHIFT/MODE_ROT constants.
//    - Slot-state encoding SLOT_EMPTY/SLOT_FULL.
//  - Sub-module barrel_shift_core: purely combinational log2(WIDTH)-stage mux shifter.
//    - Inputs: data, amt, dir, rot.
//    - Instantiated once behind the grant mux.
//  - Arbiter, slot FSM and counters live in this module.
// TESTING
//  1. in0: 0x80, amt=4, right, shift -> out 0x08, src 0, one cycle later; gcnt0=1.
//  2. in1: 0x81, amt=1, left, rotate -> 0x03; 0xFF, amt=7, right, rotate -> 0xFF;
//     0xFF, amt=7, left, shift -> 0x80.
//  3. Both valid continuously after reset, out_ready=1:
//     grants alternate 0,1,0,1; out_src matches; no idle cycles.
//  4. out_ready=0 for 5 cycles with both valid:
//     one result held stable, both readies 0; on release the next result follows with no bubble.
//  5. Only in0 valid for 256 ops -> gcnt0 wraps to 0 and gcnt1 stays 0; in0 is never starved.
//  6. rst asserted while out_valid=1 and out_ready=0:
//     next cycle out_valid=0, counters 0; the first tie then goes to requester 0.

Source files
------------

// File: rtl/bshift_pkg.sv
// ---------------------------------------------------------------------------
// bshift_pkg
// Shared definitions for the two-requester barrel shifter arbiter.
//   DEF_WIDTH / DEF_SHW / DEF_CNTW : default data, shift-amount and counter widths
//   DIR_LEFT / DIR_RIGHT           : encoding of the per-op direction bit
//   MODE_SHIFT / MODE_ROT          : encoding of the per-op rotate bit
//   slot_state_t                   : one-entry output slot state (SLOT_EMPTY/SLOT_FULL)
// ---------------------------------------------------------------------------
package bshift_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SHW   = 3;
  localparam int DEF_CNTW  = 8;

  localparam logic DIR_LEFT   = 1'b0;
  localparam logic DIR_RIGHT  = 1'b1;
  localparam logic MODE_SHIFT = 1'b0;
  localparam logic MODE_ROT   = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/barrel_shift_core.sv
// ---------------------------------------------------------------------------
// barrel_shift_core
// Purely combinational log2(WIDTH)-stage mux barrel shifter.
//   data   in  WIDTH  operand
//   amt    in  SHW    shift amount, 0..WIDTH-1
//   dir    in  1      DIR_LEFT / DIR_RIGHT
//   rot    in  1      MODE_SHIFT (zero fill) / MODE_ROT (wrap around)
//   result out WIDTH  shifted or rotated operand
// Stage i moves the word by 2**i when amt[i] is set; the stages commute, so
// the total movement is exactly amt.
// ---------------------------------------------------------------------------
module barrel_shift_core
  import bshift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amt,
  input  logic             dir,
  input  logic             rot,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] stage [SHW+1];

  assign stage[0] = data;

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    localparam int K = 1 << i;

    logic [WIDTH-1:0] cur;
    logic [K-1:0]     wrap_l;
    logic [K-1:0]     wrap_r;
    logic [WIDTH-1:0] moved;

    assign cur = stage[i];

    // Bits vacated by the move are either zeros or the bits pushed off the
    // opposite end, depending on the mode.
    assign wrap_l = (rot == MODE_ROT) ? cur[WIDTH-1:WIDTH-K] : {K{1'b0}};
    assign wrap_r = (rot == MODE_ROT) ? cur[K-1:0]           : {K{1'b0}};

    assign moved = (dir == DIR_RIGHT) ? {wrap_r, cur[WIDTH-1:K]}
                                      : {cur[WIDTH-1-K:0], wrap_l};

    assign stage[i+1] = amt[i] ? moved : cur;
  end

  assign result = stage[SHW];

endmodule

// File: rtl/barrel_shift_arbiter.sv
// ---------------------------------------------------------------------------
// barrel_shift_arbiter
// Shares one barrel shifter between two requesters with round-robin
// arbitration and a one-entry registered result slot.
//   clk, rst                    clock, synchronous active-high reset
//   inK_valid/ready             requester K handshake (K = 0, 1)
//   inK_data/amt/dir/rot        requester K operand and shift control
//   out_valid/ready             result slot handshake
//   out_data, out_src           shifted result and the requester it came from
//   gcnt0, gcnt1                wrapping count of ops accepted per requester
// ---------------------------------------------------------------------------
module barrel_shift_arbiter
  import bshift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic [SHW-1:0]   in0_amt,
  input  logic             in0_dir,
  input  logic             in0_rot,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic [SHW-1:0]   in1_amt,
  input  logic             in1_dir,
  input  logic             in1_rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [CNTW-1:0]  gcnt0,
  output logic [CNTW-1:0]  gcnt1
);

  slot_state_t      slot_state;
  slot_state_t      slot_next;
  logic             last_grant;
  logic             slot_free;
  logic             grant0;
  logic             grant1;
  logic             granted;
  logic [WIDTH-1:0] sel_data;
  logic [SHW-1:0]   sel_amt;
  logic             sel_dir;
  logic             sel_rot;
  logic [WIDTH-1:0] shifted;

  // The slot can accept a new op when it is empty, or when it is full and
  // the consumer is draining it this very cycle (back-to-back refill).
  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    slot_free = (slot_state == SLOT_EMPTY) || out_ready;
    grant0    = 1'b0;
    grant1    = 1'b0;
    slot_next = slot_state;

    if (!rst && slot_free) begin
      if (in0_valid && in1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = in0_valid;
        grant1 = in1_valid;
      end
    end

    granted = grant0 || grant1;

    case (slot_state)
      SLOT_EMPTY: if (granted) slot_next = SLOT_FULL;
      SLOT_FULL: begin
        if (granted)        slot_next = SLOT_FULL;
        else if (out_ready) slot_next = SLOT_EMPTY;
      end
      default: slot_next = SLOT_EMPTY;
    endcase
  end

  assign in0_ready = grant0;
  assign in1_ready = grant1;

  // Only the granted op reaches the shifter; requester 0 is the default
  // when nothing is granted since the result is not captured then.
  assign sel_data = grant1 ? in1_data : in0_data;
  assign sel_amt  = grant1 ? in1_amt  : in0_amt;
  assign sel_dir  = grant1 ? in1_dir  : in0_dir;
  assign sel_rot  = grant1 ? in1_rot  : in0_rot;

  barrel_shift_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .data   (sel_data),
    .amt    (sel_amt),
    .dir    (sel_dir),
    .rot    (sel_rot),
    .result (shifted)
  );

  // Reset leaves last_grant pointing at requester 1 so requester 0 wins the
  // first tie. The result registers only move on a grant, so a held result
  // stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_state <= SLOT_EMPTY;
      last_grant <= 1'b1;
      out_data   <= '0;
      out_src    <= 1'b0;
      gcnt0      <= '0;
      gcnt1      <= '0;
    end else begin
      slot_state <= slot_next;
      if (granted) begin
        out_data   <= shifted;
        out_src    <= grant1;
        last_grant <= grant1;
      end
      if (grant0) gcnt0 <= gcnt0 + CNTW'(1);
      if (grant1) gcnt1 <= gcnt1 + CNTW'(1);
    end
  end

  assign out_valid = (slot_state == SLOT_FULL);

endmodule
